// File: rtl/dm_port_arbiter.sv
// Shares the data-memory port between the CPU MEM stage and the debug unit, one access per 4 cycles.
// Optional debug port and starvation counter are enabled by defining DM_ARB_DEBUG_EN.
module dm_port_arbiter #(
   parameter int unsigned ADDR_W   = 32,
   parameter int unsigned DATA_W   = 32,
   parameter int unsigned MAX_WAIT = 4
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              cpu_req_i,
   input  logic              cpu_we_i,
   input  logic [2:0]        cpu_mode_i,
   input  logic [ADDR_W-1:0] cpu_addr_i,
   input  logic [DATA_W-1:0] cpu_din_i,
   output logic [DATA_W-1:0] cpu_dout_o,
   output logic              cpu_ack_o,
   output logic              cpu_err_o,
   output logic              cpu_stall_o,
   input  logic              dbg_req_i,
   input  logic              dbg_we_i,
   input  logic [ADDR_W-1:0] dbg_addr_i,
   input  logic [DATA_W-1:0] dbg_din_i,
   output logic [DATA_W-1:0] dbg_dout_o,
   output logic              dbg_ack_o,
   output logic              dbg_err_o,
   output logic              mem_we_o,
   output logic [2:0]        mem_mode_o,
   output logic [ADDR_W-1:0] mem_addr_o,
   output logic [DATA_W-1:0] mem_din_o,
   input  logic [DATA_W-1:0] mem_dout_i,
   input  logic              mem_error_i
);

   typedef enum logic [1:0] {StIdle, StIssue, StResp, StDone} state_e;

   state_e              state_q, state_d;
   logic                grant_cpu, grant_dbg;
   logic                capture, ack_set;
   logic                owner_dbg_q;
   logic                we_q;
   logic [2:0]          mode_q;
   logic [ADDR_W-1:0]   addr_q;
   logic [DATA_W-1:0]   din_q;
   logic [DATA_W-1:0]   cpu_dout_q;
   logic                cpu_err_q, cpu_ack_q;

`ifdef DM_ARB_DEBUG_EN
   logic [3:0]          wait_cnt_q, wait_cnt_d;
   logic                starved;
   logic [DATA_W-1:0]   dbg_dout_q;
   logic                dbg_err_q, dbg_ack_q;

   // Debug only wins when the CPU is absent or debug has waited MAX_WAIT CPU grants.
   assign starved   = (wait_cnt_q == 4'(MAX_WAIT));
   assign grant_dbg = dbg_req_i & (~cpu_req_i | starved);
`else
   logic                unused_dbg;

   assign unused_dbg = ^{dbg_req_i, dbg_we_i, dbg_addr_i, dbg_din_i};
   assign grant_dbg  = 1'b0;
`endif

   assign grant_cpu = cpu_req_i & ~grant_dbg;

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q <= StIdle;
      end else begin
         state_q <= state_d;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:  if (grant_cpu | grant_dbg) state_d = StIssue;
         StIssue: state_d = StResp;
         StResp:  state_d = StDone;
         StDone:  state_d = StIdle;
         default: state_d = StIdle;
      endcase
   end

   always_comb begin
      mem_we_o = 1'b0;
      capture  = 1'b0;
      ack_set  = 1'b0;
      unique case (state_q)
         StIssue: mem_we_o = we_q;
         StResp: begin
            capture = 1'b1;
            ack_set = 1'b1;
         end
         default: ;
      endcase
   end

   // Request latch; these registers also hold the memory address/data between accesses.
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         owner_dbg_q <= 1'b0;
         we_q        <= 1'b0;
         mode_q      <= 3'b000;
         addr_q      <= '0;
         din_q       <= '0;
      end else if (state_q == StIdle && state_d == StIssue) begin
         owner_dbg_q <= grant_dbg;
         if (grant_dbg) begin
            we_q   <= dbg_we_i;
            mode_q <= 3'b010;
            addr_q <= dbg_addr_i;
            din_q  <= dbg_din_i;
         end else begin
            we_q   <= cpu_we_i;
            mode_q <= cpu_mode_i;
            addr_q <= cpu_addr_i;
            din_q  <= cpu_din_i;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         cpu_dout_q <= '0;
         cpu_err_q  <= 1'b0;
         cpu_ack_q  <= 1'b0;
      end else begin
         cpu_ack_q <= ack_set & ~owner_dbg_q;
         if (capture & ~owner_dbg_q) begin
            cpu_dout_q <= mem_dout_i;
            cpu_err_q  <= mem_error_i;
         end
      end
   end

`ifdef DM_ARB_DEBUG_EN
   always_comb begin
      wait_cnt_d = wait_cnt_q;
      if (state_q == StIdle) begin
         if (grant_dbg) begin
            wait_cnt_d = 4'd0;
         end else if (grant_cpu & dbg_req_i & ~starved) begin
            wait_cnt_d = wait_cnt_q + 4'd1;
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         wait_cnt_q <= 4'd0;
         dbg_dout_q <= '0;
         dbg_err_q  <= 1'b0;
         dbg_ack_q  <= 1'b0;
      end else begin
         wait_cnt_q <= wait_cnt_d;
         dbg_ack_q  <= ack_set & owner_dbg_q;
         if (capture & owner_dbg_q) begin
            dbg_dout_q <= mem_dout_i;
            dbg_err_q  <= mem_error_i;
         end
      end
   end

   assign dbg_dout_o = dbg_dout_q;
   assign dbg_err_o  = dbg_err_q;
   assign dbg_ack_o  = dbg_ack_q;
`else
   assign dbg_dout_o = '0;
   assign dbg_err_o  = 1'b0;
   assign dbg_ack_o  = 1'b0;
`endif

   assign cpu_dout_o  = cpu_dout_q;
   assign cpu_err_o   = cpu_err_q;
   assign cpu_ack_o   = cpu_ack_q;
   assign cpu_stall_o = cpu_req_i & ~cpu_ack_q;
   assign mem_mode_o  = mode_q;
   assign mem_addr_o  = addr_q;
   assign mem_din_o   = din_q;

endmodule

// File: tb/tb_dm_port_arbiter.sv
// Random CPU/debug traffic against a transaction-level model of dm_port_arbiter.
// Debug-port expectations follow DM_ARB_DEBUG_EN, as in the design.
module tb_dm_port_arbiter;

   localparam int MW = 4;
`ifdef DM_ARB_DEBUG_EN
   localparam bit DbgEn = 1'b1;
`else
   localparam bit DbgEn = 1'b0;
`endif

   logic        clk = 1'b0;
   logic        rst;
   logic        cpu_req, cpu_we, cpu_ack, cpu_err, cpu_stall;
   logic [2:0]  cpu_mode;
   logic [31:0] cpu_addr, cpu_din, cpu_dout;
   logic        dbg_req, dbg_we, dbg_ack, dbg_err;
   logic [31:0] dbg_addr, dbg_din, dbg_dout;
   logic        mem_we, mem_error;
   logic [2:0]  mem_mode;
   logic [31:0] mem_addr, mem_din, mem_dout;

   always #5 clk = ~clk;

   dm_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MAX_WAIT(MW)) dut (
      .clk_i(clk), .rst_i(rst),
      .cpu_req_i(cpu_req), .cpu_we_i(cpu_we), .cpu_mode_i(cpu_mode), .cpu_addr_i(cpu_addr),
      .cpu_din_i(cpu_din), .cpu_dout_o(cpu_dout), .cpu_ack_o(cpu_ack), .cpu_err_o(cpu_err),
      .cpu_stall_o(cpu_stall),
      .dbg_req_i(dbg_req), .dbg_we_i(dbg_we), .dbg_addr_i(dbg_addr), .dbg_din_i(dbg_din),
      .dbg_dout_o(dbg_dout), .dbg_ack_o(dbg_ack), .dbg_err_o(dbg_err),
      .mem_we_o(mem_we), .mem_mode_o(mem_mode), .mem_addr_o(mem_addr), .mem_din_o(mem_din),
      .mem_dout_i(mem_dout), .mem_error_i(mem_error)
   );

   function automatic logic [31:0] init_val(int i);
      return (i == 16) ? 32'hDEADBEEF : (32'(i) * 32'h9E3779B9) ^ 32'h5A5A1234;
   endfunction

   // Memory with one-cycle synchronous read; addresses with bit 30 set report an error.
   logic [31:0] env_mem [256];
   always @(posedge clk) begin
      if (rst) begin
         for (int i = 0; i < 256; i++) env_mem[i] <= init_val(i);
         mem_dout  <= '0;
         mem_error <= 1'b0;
      end else begin
         if (mem_we) env_mem[mem_addr[7:0]] <= mem_din;
         mem_dout  <= env_mem[mem_addr[7:0]];
         mem_error <= mem_addr[30];
      end
   end

   int errors = 0;
   int checks = 0;

   // Reference model: an access granted at edge g is issued after g, acked after g+2,
   // and the port is free to grant again at edge g+4.
   int          e, g, next_free, wcnt;
   bit          act, own_dbg, rst_edge, rst_pending;
   logic        we_x, eexp;
   logic [2:0]  mode_x;
   logic [31:0] addr_x, din_x, dexp;
   logic [31:0] shadow [256];
   logic [31:0] cdout_h, ddout_h;
   bit          cerr_h, derr_h, cdout_ok, ddout_ok;
   int          cpu_acks_exp, cpu_acks_obs, dbg_acks_exp, dbg_acks_obs;

   task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      act = 1'b0; wcnt = 0;
      cdout_h = '0; ddout_h = '0; cerr_h = 1'b0; derr_h = 1'b0;
      cdout_ok = 1'b1; ddout_ok = 1'b1;
      for (int i = 0; i < 256; i++) shadow[i] = init_val(i);
   endtask

   task automatic new_cpu();
      cpu_we   = 1'($urandom_range(0, 1));
      cpu_mode = 3'($urandom_range(0, 7));
      cpu_addr = {1'b0, ($urandom_range(0, 11) == 0), 22'd0, 8'($urandom_range(0, 255))};
      cpu_din  = $urandom;
   endtask

   task automatic new_dbg();
      dbg_we   = 1'($urandom_range(0, 1));
      dbg_addr = {1'b0, ($urandom_range(0, 7) == 0), 22'd0, 8'($urandom_range(0, 255))};
      dbg_din  = $urandom;
   endtask

   task automatic tick(int cpu_pct, int dbg_pct, int keep_pct);
      bit cack, dack, dw;
      @(negedge clk);
      cack = act && !own_dbg && (e == g + 2);
      dack = act && own_dbg && (e == g + 2);
      if (rst_edge) begin
         chk("rst_cpu_ack", cpu_ack, 0);   chk("rst_dbg_ack", dbg_ack, 0);
         chk("rst_cpu_dout", cpu_dout, 0); chk("rst_dbg_dout", dbg_dout, 0);
         chk("rst_cpu_err", cpu_err, 0);   chk("rst_dbg_err", dbg_err, 0);
         chk("rst_mem_we", mem_we, 0);     chk("rst_mem_addr", mem_addr, 0);
         chk("rst_mem_din", mem_din, 0);   chk("rst_mem_mode", mem_mode, 0);
         chk("rst_cpu_stall", cpu_stall, cpu_req);
         rst_edge = 1'b0;
      end else begin
         if (cack) begin
            cerr_h = eexp; cdout_h = dexp; cdout_ok = !we_x; cpu_acks_exp++;
         end
         if (dack) begin
            derr_h = eexp; ddout_h = dexp; ddout_ok = !we_x; dbg_acks_exp++;
         end
         if (cpu_ack === 1'b1) cpu_acks_obs++;
         if (dbg_ack === 1'b1) dbg_acks_obs++;
         chk("cpu_ack", cpu_ack, cack);
         chk("dbg_ack", dbg_ack, dack);
         chk("cpu_stall", cpu_stall, cpu_req & ~cack);
         chk("cpu_err", cpu_err, cerr_h);
         chk("dbg_err", dbg_err, derr_h);
         if (cdout_ok) chk("cpu_dout", cpu_dout, cdout_h);
         if (ddout_ok) chk("dbg_dout", dbg_dout, ddout_h);
         chk("mem_we", mem_we, act && (e == g) && we_x);
         chk("mem_addr", mem_addr, act ? addr_x : 32'd0);
         chk("mem_din", mem_din, act ? din_x : 32'd0);
         chk("mem_mode", mem_mode, act ? mode_x : 3'd0);
      end
      // Requesters hold fields until acked, then drop or immediately re-request.
      if (cack) begin
         cpu_req = ($urandom_range(1, 100) <= keep_pct);
         if (cpu_req) new_cpu();
      end else if (!cpu_req && $urandom_range(1, 100) <= cpu_pct) begin
         cpu_req = 1'b1; new_cpu();
      end
      if (dack) begin
         dbg_req = ($urandom_range(1, 100) <= keep_pct);
         if (dbg_req) new_dbg();
      end else if (!dbg_req && $urandom_range(1, 100) <= dbg_pct) begin
         dbg_req = 1'b1; new_dbg();
      end
      rst = 1'b0;
      if (rst_pending && act && (e + 1 == g + 2)) begin
         rst = 1'b1; rst_pending = 1'b0;
      end else if (e + 1 >= next_free) begin
         dw = DbgEn && dbg_req && (!cpu_req || wcnt == MW);
         if (dw || cpu_req) begin
            g = e + 1; act = 1'b1; next_free = g + 4; own_dbg = dw;
            if (dw) begin
               we_x = dbg_we; mode_x = 3'b010; addr_x = dbg_addr; din_x = dbg_din; wcnt = 0;
            end else begin
               we_x = cpu_we; mode_x = cpu_mode; addr_x = cpu_addr; din_x = cpu_din;
               if (DbgEn && dbg_req && wcnt < MW) wcnt++;
            end
            dexp = shadow[addr_x[7:0]];
            eexp = addr_x[30];
            if (we_x) shadow[addr_x[7:0]] = din_x;
         end
      end
      @(posedge clk);
      e++;
      if (rst) begin
         model_reset();
         rst_edge = 1'b1;
         next_free = e + 1;
      end
   endtask

   initial begin
      rst = 1'b1;
      cpu_req = 1'b1; cpu_we = 1'b0; cpu_mode = 3'b010; cpu_addr = 32'h10; cpu_din = 32'h0;
      dbg_req = 1'b0; dbg_we = 1'b0; dbg_addr = 32'h0; dbg_din = 32'h0;
      cpu_acks_exp = 0; cpu_acks_obs = 0; dbg_acks_exp = 0; dbg_acks_obs = 0;
      rst_pending = 1'b0; g = -10;
      model_reset();
      @(posedge clk);
      e = 0; rst_edge = 1'b1; next_free = 1;
      // CPU-only traffic; the first access reads 0xDEADBEEF from address 0x10.
      for (int i = 0; i < 300; i++) tick(40, 0, 30);
      // Mixed traffic with one reset landing in the RESP cycle of an access.
      for (int i = 0; i < 200; i++) tick(50, 50, 50);
      rst_pending = 1'b1;
      for (int i = 0; i < 250; i++) tick(50, 50, 50);
      // CPU requests back-to-back while debug waits: exercises the starvation bound.
      for (int i = 0; i < 300; i++) tick(100, 60, 100);
      for (int i = 0; i < 200; i++) tick(30, 80, 20);
      chk("cpu_ack_count", cpu_acks_obs, cpu_acks_exp);
      chk("dbg_ack_count", dbg_acks_obs, dbg_acks_exp);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/dm_port_arbiter.md
# dm_port_arbiter

Arbitrates the single read/write port of the data-memory unit between the CPU MEM stage and the debug/program-download unit. It latches one request, sequences it through the memory's one-cycle synchronous read, and returns data, error and a one-cycle acknowledge to the winning requester. It sits between the pipeline/debug logic and the data-memory port (`we`, `mode`, `addr`, `din`, `dout`, `error`). The CPU has priority, with a starvation counter that bounds debug wait time.

## Interface
- `ADDR_W`, 32, address width
- `DATA_W`, 32, data width
- `MAX_WAIT`, 4, consecutive CPU grants while debug is pending before debug is forced (1..15)

- `clk`  in  1  system clock; all state on rising edge
- `rst`  in  1  synchronous, active-high reset
- `cpu_req`, `cpu_we`  in  1  CPU request / write flag
- `cpu_mode`  in  3  access size/sign code, passed through unchanged
- `cpu_addr`  in  ADDR_W; `cpu_din`  in  DATA_W
- `cpu_dout`  out  DATA_W  read data, valid with `cpu_ack`, held until next CPU ack
- `cpu_ack`  out  1  one-cycle completion pulse
- `cpu_err`  out  1  memory error, valid with `cpu_ack`
- `cpu_stall`  out  1  `cpu_req & ~cpu_ack`
- `dbg_req`, `dbg_we`, `dbg_addr`, `dbg_din`, `dbg_dout`, `dbg_ack`, `dbg_err`: same as the CPU equivalents, for the debug port; no mode input
- `mem_we`  out  1; `mem_mode`  out  3; `mem_addr`  out  ADDR_W; `mem_din`  out  DATA_W
- `mem_dout`  in  DATA_W; `mem_error`  in  1

## Operation
- **FSM states:** IDLE, ISSUE, RESP, DONE.
- **IDLE:**
  - If a request is pending, choose the owner, latch `we`/`mode`/`addr`/`din` into internal registers, and go to ISSUE.
  - Debug mode is fixed at 3'b010 (word).
  - If no request is pending, stay in IDLE.
- **ISSUE:** drive `mem_*` from the latched registers. `mem_we` = latched `we` in this cycle only. Next state is RESP.
- **RESP:** `mem_addr`/`mem_mode` are held and `mem_we`=0. Capture `mem_dout` into the owner's dout register and `mem_error` into the owner's err register. Next state is DONE.
- **DONE:** assert the owner's `*_ack` (registered pulse). Next state is IDLE. No new grant is made in DONE.
- **Priority:**
  - CPU wins over debug unless `wait_cnt == MAX_WAIT`, in which case debug wins.
  - `wait_cnt` increments (saturating at MAX_WAIT) on each CPU grant made while `dbg_req`=1.
  - `wait_cnt` clears on every debug grant.
- **Writes:**
  - On a write, the dout register still captures `mem_dout`; its content is don't-care for the requester.
  - `*_err` is valid for both reads and writes.
- **Requester handshake:**
  - Hold `req` and all fields stable from assertion until `ack`.
  - `req` may stay high in the cycle after `ack`; it is then treated as a new request.
  - Dropping `req` before `ack` is illegal. The latched access completes regardless.
- **Idle outputs:** `mem_addr`/`mem_din` hold their last values and `mem_we`=0 outside ISSUE.

## Timing
- **Latency:** request sampled in IDLE at cycle 0 → ISSUE at c1 → RESP at c2 → DONE at c3 (`ack`=1, dout valid). The next grant can be sampled at c4.
- **Throughput:** 4 cycles per access. Back-to-back requests from the same requester give one ack every 4 cycles.
- **Simultaneous `cpu_req` and `dbg_req` in IDLE:** exactly one grant is made; the loser waits in IDLE and its stall continues.
- **Reset values:**
  - state = IDLE; `wait_cnt` = 0; latched regs = 0.
  - Outputs: all `*_dout`=0, `*_ack`=0, `*_err`=0, `mem_we`=0, `mem_addr`=0, `mem_din`=0, `mem_mode`=0.
  - `cpu_stall` = `cpu_req`.
- **Reset mid-access:** at the reset edge, return to IDLE and issue no ack. The aborted requester must re-issue. A write already presented in ISSUE may have committed.

## Configuration
- **`DM_ARB_DEBUG_EN` defined:** the debug port and starvation counter are active, as described above.
- **`DM_ARB_DEBUG_EN` undefined:**
  - `dbg_*` inputs are ignored.
  - `dbg_dout`/`dbg_ack`/`dbg_err` are tied to 0.
  - `wait_cnt` is removed.
  - The CPU is the only requester; timing is unchanged.

## Test plan
- **CPU read:** reset, then `cpu_req`=1, `we`=0, `addr`=0x10, with the memory model returning 0xDEADBEEF → `mem_addr`=0x10 at c1, `cpu_ack`=1 and `cpu_dout`=0xDEADBEEF at c3, `cpu_stall`=1 during c0–c2.
- **CPU write:** `we`=1, `addr`=0x20, `din`=0x12345678, `mode`=3'b001 → `mem_we`=1 for exactly one cycle (c1) with `mem_mode`=3'b001; ack at c3; the memory model holds 0x12345678.
- **Simultaneous requests:** CPU and debug both request at c0 → CPU acked at c3, debug granted at c4 and acked at c7 with `mem_mode`=3'b010.
- **Starvation bound:** `cpu_req` held continuously, `dbg_req` raised, MAX_WAIT=4 → after 4 CPU acks the 5th grant goes to debug; `wait_cnt` returns to 0.
- **Reset mid-access:** assert `rst` during RESP → no ack in any cycle, all outputs at reset values on the next cycle, and a fresh request afterwards completes normally.
- **Error path:** `mem_error`=1 during RESP of a debug read → `dbg_err`=1 together with `dbg_ack`; `cpu_err` stays 0.
